// File: rtl/vision_pkg.sv
// vision_pkg: constants and types shared by the vision stage sequencer.
//   SRAM_ADDR_W / SRAM_DATA_W : width of the single shared SRAM port.
//   STG_*                     : index of each vision stage in the run order.
//   seq_state_e               : sequencer FSM state.
package vision_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 32;

    localparam int STG_CAPTURE      = 0;
    localparam int STG_COLOR        = 1;
    localparam int STG_BLOB_EXTRACT = 2;
    localparam int STG_BLOB_SORT    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        RUN     = 3'd2,
        RELEASE = 3'd3,
        FINISH  = 3'd4,
        ABORT   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/vision_stage_sequencer_sram_owner_mux.sv
// sram_owner_mux: routes one stage's SRAM request onto the shared SRAM port.
//   owner_valid      in  : a stage currently owns the port.
//   owner_idx        in  : index of the owning stage.
//   stage_address    in  : packed per-stage addresses, slice i = [i*ADDR_W +: ADDR_W].
//   stage_wren       in  : per-stage write enables.
//   stage_data_write in  : packed per-stage write data.
//   address/wren/data_write out : SRAM port; forced to zero with no owner, so a
//                                 stray write from an idle stage never reaches SRAM.
module sram_owner_mux #(
    parameter int NUM_STAGES = 4,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 2
) (
    input  logic                         owner_valid,
    input  logic [IDX_W-1:0]             owner_idx,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES-1:0]        stage_wren,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_data_write,
    output logic [ADDR_W-1:0]            address,
    output logic                         wren,
    output logic [DATA_W-1:0]            data_write
);

    always_comb begin
        address    = '0;
        wren       = 1'b0;
        data_write = '0;
        if (owner_valid) begin
            address    = stage_address[owner_idx*ADDR_W +: ADDR_W];
            wren       = stage_wren[owner_idx];
            data_write = stage_data_write[owner_idx*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/vision_stage_sequencer.sv
// vision_stage_sequencer: runs the per-frame vision stages in index order and
// owns the shared SRAM port on their behalf.
//   frame_start in : one-cycle pulse, accepted only when idle; samples stage_mask.
//   pause       in : freezes the timeout counter.
//   stage_mask  in : 1 = run stage, 0 = skip.
//   stage_enable/stage_done : level handshake with each stage. The sequencer
//       raises enable and holds it until the stage raises done; enable then
//       drops and the stage must drop done before the next stage is selected,
//       so each stage always sees at least one enable-low cycle between runs.
//   stage_address/stage_wren/stage_data_write in : per-stage SRAM requests.
//   address/wren/data_write out : SRAM port, driven only by the running stage.
//   busy out, frame_done out (pulse), error out (sticky), error_stage out.
//   dbg_state out : current FSM state for observation.
// Optional: define VISION_SEQ_PROFILE_EN to add stage_cycles, a saturating
// per-stage count of RUN cycles in the last frame.
module vision_stage_sequencer
    import vision_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int ADDR_W         = SRAM_ADDR_W,
    parameter int DATA_W         = SRAM_DATA_W,
    parameter int TIMEOUT_CYCLES = 2000000,
    localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic                         pause,
    input  logic [NUM_STAGES-1:0]        stage_mask,
    output logic [NUM_STAGES-1:0]        stage_enable,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES-1:0]        stage_wren,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_data_write,
    output logic [ADDR_W-1:0]            address,
    output logic                         wren,
    output logic [DATA_W-1:0]            data_write,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         error,
    output logic [IDX_W-1:0]             error_stage,
`ifdef VISION_SEQ_PROFILE_EN
    output logic [NUM_STAGES*32-1:0]     stage_cycles,
`endif
    output logic [2:0]                   dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      stage_q, stage_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic                  error_q, error_d;
    logic [IDX_W-1:0]      err_stage_q, err_stage_d;

    logic cur_done;
    logic cur_mask;
    logic is_last;
    logic cnt_step;
    logic timeout_hit;

    assign cur_done    = stage_done[stage_q];
    assign cur_mask    = mask_q[stage_q];
    assign is_last     = (stage_q == LAST_IDX);
    // The counter saturates at its abort value so it can never wrap back.
    assign cnt_step    = !pause && (cnt_q != CNT_MAX);
    assign timeout_hit = !pause && (cnt_q == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        error_d     = error_q;
        err_stage_d = err_stage_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    mask_d  = stage_mask;
                    error_d = 1'b0;
                    stage_d = '0;
                    cnt_d   = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (cur_mask) begin
                    state_d = RUN;
                end else if (is_last) begin
                    state_d = FINISH;
                end else begin
                    stage_d = stage_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_step) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Done is checked before the timeout so a stage finishing on
                // the last allowed cycle is not aborted.
                if (cur_done) begin
                    state_d = RELEASE;
                end else if (timeout_hit) begin
                    state_d     = ABORT;
                    error_d     = 1'b1;
                    err_stage_d = stage_q;
                end
            end
            RELEASE: begin
                if (cnt_step) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!cur_done) begin
                    if (is_last) begin
                        state_d = FINISH;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        cnt_d   = '0;
                        state_d = SELECT;
                    end
                end else if (timeout_hit) begin
                    state_d     = ABORT;
                    error_d     = 1'b1;
                    err_stage_d = stage_q;
                end
            end
            FINISH: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            ABORT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            error_q     <= 1'b0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            error_q     <= error_d;
            err_stage_q <= err_stage_d;
        end
    end

    always_comb begin
        stage_enable = '0;
        if (state_q == RUN) begin
            stage_enable[stage_q] = 1'b1;
        end
    end

    assign busy        = (state_q == SELECT) || (state_q == RUN) || (state_q == RELEASE);
    assign frame_done  = (state_q == FINISH);
    assign error       = error_q;
    assign error_stage = err_stage_q;
    assign dbg_state   = state_q;

    sram_owner_mux #(
        .NUM_STAGES (NUM_STAGES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) u_owner_mux (
        .owner_valid      (state_q == RUN),
        .owner_idx        (stage_q),
        .stage_address    (stage_address),
        .stage_wren       (stage_wren),
        .stage_data_write (stage_data_write),
        .address          (address),
        .wren             (wren),
        .data_write       (data_write)
    );

`ifdef VISION_SEQ_PROFILE_EN
    logic [31:0] prof_q [NUM_STAGES];
    logic [31:0] prof_d [NUM_STAGES];

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            prof_d[i] = prof_q[i];
        end
        if ((state_q == IDLE) && frame_start) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                prof_d[i] = '0;
            end
        end else if ((state_q == RUN) && (prof_q[stage_q] != 32'hFFFF_FFFF)) begin
            prof_d[stage_q] = prof_q[stage_q] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                prof_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                prof_q[i] <= prof_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_prof_out
        assign stage_cycles[g*32 +: 32] = prof_q[g];
    end
`endif

endmodule

// File: tb/tb_vision_stage_sequencer.sv
// tb_vision_stage_sequencer: directed frame sequence with randomised stage
// latencies and SRAM requests. A behavioural stage model answers enables at
// the falling edge; each frame is compared against the run order, run lengths
// and completion status derived from the mask and the timeout rule.
module tb_vision_stage_sequencer;
    import vision_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 18;
    localparam int DW  = 32;
    localparam int TMO = 100;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_start;
    logic            pause;
    logic [N-1:0]    stage_mask;
    logic [N-1:0]    stage_enable;
    logic [N-1:0]    stage_done = '0;
    logic [N*AW-1:0] stage_address;
    logic [N-1:0]    stage_wren;
    logic [N*DW-1:0] stage_data_write;
    logic [AW-1:0]   address;
    logic            wren;
    logic [DW-1:0]   data_write;
    logic            busy;
    logic            frame_done;
    logic            error;
    logic [1:0]      error_stage;
    logic [2:0]      dbg_state;
`ifdef VISION_SEQ_PROFILE_EN
    logic [N*32-1:0] stage_cycles;
`endif

    // Clock and reset
    always #5 clk = ~clk;

    vision_stage_sequencer #(
        .NUM_STAGES     (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .pause            (pause),
        .stage_mask       (stage_mask),
        .stage_enable     (stage_enable),
        .stage_done       (stage_done),
        .stage_address    (stage_address),
        .stage_wren       (stage_wren),
        .stage_data_write (stage_data_write),
        .address          (address),
        .wren             (wren),
        .data_write       (data_write),
        .busy             (busy),
        .frame_done       (frame_done),
        .error            (error),
        .error_stage      (error_stage),
`ifdef VISION_SEQ_PROFILE_EN
        .stage_cycles     (stage_cycles),
`endif
        .dbg_state        (dbg_state)
    );

    // Scoreboard counters
    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage model knobs (written by the stimulus only)
    int done_delay [N] = '{50, 50, 50, 50};
    int drop_delay [N] = '{2, 2, 2, 2};
    bit never_done [N] = '{0, 0, 0, 0};
    int len_adj    [N] = '{0, 0, 0, 0};

    // Stage model and observation state (written by the model only)
    int         run_cnt [N] = '{0, 0, 0, 0};
    int         rel_cnt [N] = '{0, 0, 0, 0};
    int         en_len  [N] = '{0, 0, 0, 0};
    int         en_tot  [N] = '{0, 0, 0, 0};
    logic [N-1:0] en_prev   = '0;
    logic [7:0] seen_q[$];
    int         fd_cnt   = 0;
    int         gap_viol = 0;
    int         hot_viol = 0;

    // A stage raises done after done_delay non-paused enabled cycles and drops
    // it drop_delay cycles after its enable falls.
    always @(negedge clk) begin
        if (reset) begin
            stage_done = '0;
            en_prev    = '0;
        end else begin
            if (!$onehot0(stage_enable)) hot_viol = hot_viol + 1;
            if ((stage_enable != '0) && (en_prev != '0) && (stage_enable != en_prev))
                gap_viol = gap_viol + 1;
            if (frame_done) fd_cnt = fd_cnt + 1;
            for (int i = 0; i < N; i++) begin
                if (stage_enable[i]) begin
                    if (!en_prev[i]) begin
                        run_cnt[i] = 0;
                        en_len[i]  = 0;
                        seen_q.push_back(8'(i));
                    end
                    en_len[i] = en_len[i] + 1;
                    en_tot[i] = en_tot[i] + 1;
                    if (!pause) run_cnt[i] = run_cnt[i] + 1;
                    if (!never_done[i] && (run_cnt[i] >= done_delay[i])) stage_done[i] = 1'b1;
                end else begin
                    if (en_prev[i]) rel_cnt[i] = 0;
                    if (stage_done[i]) begin
                        rel_cnt[i] = rel_cnt[i] + 1;
                        if (rel_cnt[i] >= drop_delay[i]) stage_done[i] = 1'b0;
                    end
                end
            end
            en_prev = stage_enable;
        end
    end

    // Driver tasks
    int snap_base, snap_fd, snap_gap, snap_hot;
    int snap_tot [N];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input logic [N-1:0] m);
        stage_mask  = m;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic begin_frame(input string tag, input logic [N-1:0] m);
        snap_base = seen_q.size();
        snap_fd   = fd_cnt;
        snap_gap  = gap_viol;
        snap_hot  = hot_viol;
        for (int i = 0; i < N; i++) snap_tot[i] = en_tot[i];
        start_frame(m);
        chk({tag, "_busy_on_accept"}, busy, 1'b1);
        chk({tag, "_error_clear_on_accept"}, error, 1'b0);
    endtask

    task automatic wait_en(input string tag, input int idx);
        int k = 0;
        while (!stage_enable[idx] && (k < 3000)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_wait_enable_timeout"}, k >= 3000, 1'b0);
    endtask

    // Reference: stages run in index order over the mask, truncated at the
    // aborting stage; a run lasts done_delay cycles (plus paused cycles), or
    // exactly TMO cycles when the stage times out.
    task automatic end_check(input string tag, input logic [N-1:0] m, input int abort_at);
        logic [7:0] exp_q[$];
        int k = 0;
        while (!(frame_done || (error && !busy)) && (k < 5000)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_end_timeout"}, k >= 5000, 1'b0);
        tick(3);
        for (int i = 0; i < N; i++)
            if (m[i] && ((abort_at < 0) || (i <= abort_at))) exp_q.push_back(8'(i));
        chk({tag, "_num_runs"}, seen_q.size() - snap_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (snap_base + i < seen_q.size())
                chk($sformatf("%s_order%0d", tag, i), seen_q[snap_base + i], exp_q[i]);
        for (int i = 0; i < N; i++) begin
            if (!m[i] || ((abort_at >= 0) && (i > abort_at)))
                chk($sformatf("%s_no_enable%0d", tag, i), en_tot[i] - snap_tot[i], 0);
            else if (i == abort_at)
                chk($sformatf("%s_abort_len%0d", tag, i), en_len[i], TMO);
            else
                chk($sformatf("%s_run_len%0d", tag, i), en_len[i], done_delay[i] + len_adj[i]);
        end
        chk({tag, "_frame_done_pulses"}, fd_cnt - snap_fd, (abort_at < 0) ? 1 : 0);
        chk({tag, "_error"}, error, (abort_at < 0) ? 1'b0 : 1'b1);
        if (abort_at >= 0) chk({tag, "_error_stage"}, error_stage, abort_at);
        chk({tag, "_gap_violations"}, gap_viol - snap_gap, 0);
        chk({tag, "_onehot_violations"}, hot_viol - snap_hot, 0);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_enable"}, stage_enable, '0);
        chk({tag, "_address"}, address, '0);
        chk({tag, "_wren"}, wren, 1'b0);
        chk({tag, "_data"}, data_write, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_error_stage"}, error_stage, '0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    task automatic randomize_requests();
        for (int i = 0; i < N; i++) begin
            stage_address[i*AW +: AW]    = AW'($urandom);
            stage_data_write[i*DW +: DW] = $urandom;
            stage_wren[i]                = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [N-1:0] m;
        logic [AW-1:0] a3;
        logic [DW-1:0] d3;
        logic w3;

        reset            = 1'b1;
        frame_start      = 1'b0;
        pause            = 1'b0;
        stage_mask       = '0;
        stage_address    = '0;
        stage_wren       = '0;
        stage_data_write = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_reset_values("reset");

        // Full mask, 50-cycle stages, done dropped 2 cycles after enable falls
        randomize_requests();
        begin_frame("full", 4'b1111);
        end_check("full", 4'b1111, -1);

        // Random masks and latencies
        for (int r = 0; r < 4; r++) begin
            m = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                done_delay[i] = $urandom_range(1, 60);
                drop_delay[i] = $urandom_range(1, 5);
            end
            randomize_requests();
            begin_frame($sformatf("rand%0d", r), m);
            end_check($sformatf("rand%0d", r), m, -1);
        end

        // Sparse mask: only stages 0 and 2 run
        for (int i = 0; i < N; i++) done_delay[i] = $urandom_range(5, 30);
        begin_frame("sparse", 4'b0101);
        end_check("sparse", 4'b0101, -1);

        // All-masked frame completes NUM_STAGES+1 cycles after frame_start
        begin_frame("nomask", 4'b0000);
        for (int t = 1; t <= N + 1; t++) begin
            chk($sformatf("nomask_frame_done_t%0d", t), frame_done, (t == N + 1) ? 1'b1 : 1'b0);
            if (t != N + 1) tick(1);
        end
        chk("nomask_busy_at_finish", busy, 1'b0);
        end_check("nomask", 4'b0000, -1);

        // Stage 2 never finishes: abort after TMO cycles, stage 3 never runs
        never_done[2] = 1'b1;
        begin_frame("timeout", 4'b1111);
        end_check("timeout", 4'b1111, 2);
        never_done[2] = 1'b0;
        begin_frame("after_timeout", 4'b0011);
        end_check("after_timeout", 4'b0011, -1);

        // Done on the last allowed cycle wins over the timeout
        done_delay[0] = TMO;
        drop_delay[0] = 1;
        begin_frame("done_at_limit", 4'b0001);
        end_check("done_at_limit", 4'b0001, -1);
        // One cycle later is a timeout
        done_delay[0] = TMO + 1;
        begin_frame("done_past_limit", 4'b0001);
        end_check("done_past_limit", 4'b0001, 0);
        done_delay[0] = 20;
        drop_delay[0] = 2;

        // Pause for 300 cycles inside stage 1; done after 60 non-paused cycles
        done_delay[1] = 60;
        len_adj[1]    = 300;
        begin_frame("pause", 4'b1111);
        wait_en("pause", 1);
        @(posedge clk);
        #2 pause = 1'b1;
        repeat (300) @(posedge clk);
        #2 pause = 1'b0;
        end_check("pause", 4'b1111, -1);
        len_adj[1] = 0;

        // Stage 0 writes stray data while stage 3 owns the port
        done_delay[3] = 40;
        begin_frame("mux", 4'b1111);
        wait_en("mux", 3);
        for (int it = 0; it < 8; it++) begin
            a3 = AW'($urandom);
            d3 = $urandom;
            w3 = 1'($urandom_range(0, 1));
            stage_address[0*AW +: AW]    = 18'd200000;
            stage_wren[0]                = 1'b1;
            stage_data_write[0*DW +: DW] = $urandom;
            stage_address[3*AW +: AW]    = a3;
            stage_wren[3]                = w3;
            stage_data_write[3*DW +: DW] = d3;
            #1;
            chk($sformatf("mux_address_it%0d", it), address, a3);
            chk($sformatf("mux_wren_it%0d", it), wren, w3);
            chk($sformatf("mux_data_it%0d", it), data_write, d3);
            @(negedge clk);
        end
        end_check("mux", 4'b1111, -1);
        chk("mux_idle_wren", wren, 1'b0);
        chk("mux_idle_address", address, '0);
        chk("mux_idle_data", data_write, '0);

        // A second frame_start during stage 1 is ignored
        for (int i = 0; i < N; i++) done_delay[i] = 25;
        begin_frame("restart", 4'b1111);
        wait_en("restart", 1);
        start_frame(4'b0000);
        end_check("restart", 4'b1111, -1);

        // Reset asserted during stage 2 returns everything to reset values
        begin_frame("midreset", 4'b1111);
        wait_en("midreset", 2);
        reset = 1'b1;
        tick(1);
        check_reset_values("midreset");
        reset = 1'b0;
        tick(2);
        chk("midreset_stays_idle", dbg_state, IDLE);
        chk("midreset_enable_low", stage_enable, '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
